// File: rtl/jvm_decode_sequencer_pkg.sv
// Shared definitions for the JVM decode sequencer.
// - seq_state_e      : sequencer state encoding (2-bit)
// - Q_FETCH / Q_ITER : values driven on q_select
// - WIDE_OPC_DEFAULT : default value of the WIDE prefix opcode
package jvm_decode_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_PARAMS = 2'd1,
    ST_ITER   = 2'd2
  } seq_state_e;

  localparam logic Q_FETCH = 1'b0;
  localparam logic Q_ITER  = 1'b1;

  localparam logic [7:0] WIDE_OPC_DEFAULT = 8'hC4;

endpackage

// File: rtl/jvm_decode_sequencer_if.sv
// Bundle of the sequencer's functional signals.
// master : the sequencer (consumes bytes, drives opcode/operands/microcode address)
// slave  : the surroundings (instruction buffer, count lookup, next-address ROM)
// Signals:
//   stall, ib_data, ib_valid, ib_rd      instruction-buffer handshake and freeze
//   param_count                          operand count for the current opcode
//   opcode, is_wide, params              decoded instruction
//   uc_adr, uc_next, uc_valid, q_select  microcode walk
//   err                                  operand-count overflow pulse
interface jvm_decode_sequencer_if #(
  parameter int OPC_W     = 8,
  parameter int PARAM_MAX = 4,
  parameter int PCNT_W    = 3,
  parameter int UC_ADR_W  = 10
);

  logic                       stall;
  logic [OPC_W-1:0]           ib_data;
  logic                       ib_valid;
  logic                       ib_rd;
  logic [PCNT_W-1:0]          param_count;
  logic [OPC_W-1:0]           opcode;
  logic                       is_wide;
  logic [OPC_W*PARAM_MAX-1:0] params;
  logic [UC_ADR_W-1:0]        uc_adr;
  logic [UC_ADR_W-1:0]        uc_next;
  logic                       uc_valid;
  logic                       q_select;
  logic                       err;

  modport master (
    input  stall, ib_data, ib_valid, param_count, uc_next,
    output ib_rd, opcode, is_wide, params, uc_adr, uc_valid, q_select, err
  );

  modport slave (
    output stall, ib_data, ib_valid, param_count, uc_next,
    input  ib_rd, opcode, is_wide, params, uc_adr, uc_valid, q_select, err
  );

endinterface

// File: rtl/jvm_decode_sequencer_operand_shift_reg.sv
// Operand shift register: collects operand bytes, newest byte in the LSBs.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   clear        zero the register (new instruction)
//   shift_en     shift in din (clear has priority)
//   din          operand byte
//   dout         packed operands, OPC_W*PARAM_MAX bits
module jvm_decode_sequencer_operand_shift_reg #(
  parameter int OPC_W     = 8,
  parameter int PARAM_MAX = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       shift_en,
  input  logic [OPC_W-1:0]           din,
  output logic [OPC_W*PARAM_MAX-1:0] dout
);

  localparam int PW = OPC_W * PARAM_MAX;

  logic [PW-1:0] params_q, params_d;

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    params_d = params_q;
    if (clear) begin
      params_d = '0;
    end else if (shift_en) begin
      params_d = (params_q << OPC_W) | PW'(din);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      params_q <= '0;
    end else begin
      params_q <= params_d;
    end
  end

  assign dout = params_q;

endmodule

// File: rtl/jvm_decode_sequencer.sv
// Front-end sequencer for the JVM-to-ARM translator.
// Consumes bytecode bytes (folding WIDE prefixes), gathers operand bytes,
// then walks the microcode next-address chain until a zero next address.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    jvm_decode_sequencer_if.master (handshake, decode and microcode signals)
// param_count and uc_next come from external combinational lookups of the
// current opcode / uc_adr.
module jvm_decode_sequencer
  import jvm_decode_sequencer_pkg::*;
#(
  parameter int               OPC_W     = 8,
  parameter int               PARAM_MAX = 4,
  parameter int               PCNT_W    = 3,
  parameter int               UC_ADR_W  = 10,
  parameter logic [OPC_W-1:0] WIDE_OPC  = OPC_W'(WIDE_OPC_DEFAULT)
) (
  input logic                  clk,
  input logic                  reset,
  jvm_decode_sequencer_if.master bus
);

  // One extra bit so a doubled count can never wrap.
  localparam int CNT_W = PCNT_W + 1;

  seq_state_e            state_q, state_d;
  logic [OPC_W-1:0]      opcode_q, opcode_d;
  logic                  is_wide_q, is_wide_d;
  logic [UC_ADR_W-1:0]   uc_adr_q, uc_adr_d;
  logic                  q_select_q, q_select_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [CNT_W-1:0]           target;
  logic                       over_max;
  logic                       cnt_done;
  logic                       ib_rd;
  logic                       ops_clear;
  logic                       ops_shift;
  logic [OPC_W*PARAM_MAX-1:0] params;

  assign target   = is_wide_q ? {bus.param_count, 1'b0} : {1'b0, bus.param_count};
  assign over_max = (target > CNT_W'(PARAM_MAX));
  assign cnt_done = (cnt_q == target);

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    is_wide_d  = is_wide_q;
    uc_adr_d   = uc_adr_q;
    q_select_d = q_select_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    ib_rd      = 1'b0;
    ops_clear  = 1'b0;
    ops_shift  = 1'b0;

    if (!bus.stall) begin
      unique case (state_q)
        ST_FETCH: begin
          if (bus.ib_valid) begin
            ib_rd    = 1'b1;
            opcode_d = bus.ib_data;
            if (bus.ib_data == WIDE_OPC) begin
              // Prefix: remember it and keep fetching the real opcode.
              is_wide_d = 1'b1;
            end else begin
              ops_clear = 1'b1;
              cnt_d     = '0;
              state_d   = ST_PARAMS;
            end
          end
        end

        ST_PARAMS: begin
          if (over_max) begin
            // Instruction cannot be represented; drop it without touching the buffer.
            err_d     = 1'b1;
            is_wide_d = 1'b0;
            state_d   = ST_FETCH;
          end else if (cnt_done) begin
            uc_adr_d   = UC_ADR_W'(opcode_q);
            q_select_d = Q_ITER;
            state_d    = ST_ITER;
          end else if (bus.ib_valid) begin
            ib_rd     = 1'b1;
            ops_shift = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end

        ST_ITER: begin
          if (bus.uc_next == '0) begin
            q_select_d = Q_FETCH;
            is_wide_d  = 1'b0;
            state_d    = ST_FETCH;
          end else begin
            uc_adr_d = bus.uc_next;
          end
        end

        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      opcode_q   <= '0;
      is_wide_q  <= 1'b0;
      uc_adr_q   <= '0;
      q_select_q <= Q_FETCH;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      is_wide_q  <= is_wide_d;
      uc_adr_q   <= uc_adr_d;
      q_select_q <= q_select_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  jvm_decode_sequencer_operand_shift_reg #(
    .OPC_W     (OPC_W),
    .PARAM_MAX (PARAM_MAX)
  ) u_operand_shift_reg (
    .clk      (clk),
    .reset    (reset),
    .clear    (ops_clear),
    .shift_en (ops_shift),
    .din      (bus.ib_data),
    .dout     (params)
  );

  assign bus.ib_rd    = ib_rd;
  assign bus.opcode   = opcode_q;
  assign bus.is_wide  = is_wide_q;
  assign bus.params   = params;
  assign bus.uc_adr   = uc_adr_q;
  assign bus.uc_valid = (state_q == ST_ITER);
  assign bus.q_select = q_select_q;
  assign bus.err      = err_q;

endmodule

// File: doc/jvm_decode_sequencer.md
# jvm_decode_sequencer

Parametrised front-end sequencer for the JVM-to-ARM translator. It consumes bytecode bytes from the instruction buffer with a valid/read handshake and folds `WIDE` prefixes. It gathers a variable number of operand bytes into a packed operand register, then walks the microcode address chain until the terminating zero address. It sits between the instruction-buffer reader and the microcode ROM / emitter queue.

## Interface
Parameters:
- `OPC_W`, default 8: opcode and bytecode byte width.
- `PARAM_MAX`, default 4: maximum operand bytes per instruction, after `WIDE` doubling.
- `PCNT_W`, default 3: width of operand-count input; must satisfy 2^PCNT_W > PARAM_MAX.
- `UC_ADR_W`, default 10: microcode address width; must be ≥ OPC_W.
- `WIDE_OPC`, default 8'hC4: prefix opcode value.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `stall`  in  1  freezes all state; `ib_rd` forced 0.
- `ib_data`  in  OPC_W  current instruction-buffer byte.
- `ib_valid`  in  1  `ib_data` valid.
- `ib_rd`  out  1  combinational; byte consumed this cycle.
- `param_count`  in  PCNT_W  operand-byte count for `opcode`, from external combinational lookup.
- `opcode`  out  OPC_W  latched opcode.
- `is_wide`  out  1  current instruction carries `WIDE` prefix.
- `params`  out  OPC_W*PARAM_MAX  packed operands; last byte received in LSBs.
- `uc_adr`  out  UC_ADR_W  current microcode address.
- `uc_next`  in  UC_ADR_W  next-address ROM output for `uc_adr`; 0 terminates.
- `uc_valid`  out  1  `uc_adr` valid; high only in ITER.
- `q_select`  out  1  0 = fetch queue, 1 = iterate queue.
- `err`  out  1  one-cycle pulse when the operand target exceeds `PARAM_MAX`.

## Operation
- States: FETCH, PARAMS, ITER, encoded in a 2-bit register.
- Reset values: state=FETCH, `opcode`=0, `is_wide`=0, `params`=0, `uc_adr`=0, `q_select`=0, `err`=0, operand counter=0.
- All transitions are gated by `!stall`. `ib_rd` = state∈{FETCH,PARAMS} & `ib_valid` & `!stall` & not-done.
- FETCH behaviour, with `ib_valid`:
  - Latch `opcode` from `ib_data`.
  - If the byte equals `WIDE_OPC`: set `is_wide` and stay in FETCH. Repeated prefixes are idempotent.
  - Otherwise: clear `params` and the counter, then go to PARAMS.
- PARAMS, target computation: target = `is_wide` ? `param_count`<<1 : `param_count`. Compute it at PCNT_W+1 bits.
- PARAMS, target > `PARAM_MAX`: pulse `err`, clear `is_wide`, go to FETCH. No `ib_rd`.
- PARAMS, counter == target (includes 0):
  - `uc_adr` ← zero-extended `opcode`.
  - `q_select` ← 1, then go to ITER.
  - No byte is consumed this cycle.
- PARAMS, otherwise with `ib_valid`:
  - `params` ← (`params` << OPC_W) | `ib_data`.
  - Increment the counter.
- ITER, `uc_next` == 0: go to FETCH, `q_select` ← 0, clear `is_wide`.
- ITER, otherwise: `uc_adr` ← `uc_next`.
- `uc_valid` = (state==ITER).
- `ib_valid` low holds state; the counter and `params` are unchanged.
- Async reset mid-instruction discards the partial instruction. After release, fetching restarts cleanly in FETCH.

## Timing
- One byte per cycle maximum.
- An instruction with N operand bytes under continuous `ib_valid` and no stall:
  - 1 cycle FETCH, N+1 cycles PARAMS, then K cycles ITER for a chain of K addresses. The last address is the one whose `uc_next`=0.
  - The `WIDE` prefix adds 1 cycle.
- The next opcode's FETCH cycle immediately follows the terminating ITER cycle. There are no idle bubbles.
- `param_count` and `uc_next` are sampled in the same cycle as the current `opcode` / `uc_adr`, so the lookups must be combinational.
- `err` is registered and asserts the cycle after detection.

## Structure
- Shared package / `me_consts.vh`: state encodings, `WIDE_OPC` default, `Q_FETCH`/`Q_ITER` values.
- The next-address ROM stays external (`next_adr_rom`), so the sequencer stays ROM-agnostic.
- Sub-module: `operand_shift_reg`, parametrised by OPC_W and PARAM_MAX, with clear, shift-enable and packed output.

## Test plan
- Opcode 0x60 (`iadd`, count 0), chain 0x60→0 → FETCH, PARAMS, ITER; `uc_adr`=0x060 for one cycle; `params`=0; next FETCH on the 4th cycle.
- 0x10 (`bipush`, count 1), byte 0x7F → `params` LSB=0x7F; ITER starts 3 cycles after the opcode cycle.
- 0xC4, 0x84 (`iinc`, count 2) + bytes 01 02 03 04 → `is_wide`=1, `params`=0x01020304; `is_wide` clears after ITER.
- 0xC4 + count 3 (target 6 > 4) → `err` pulse, return to FETCH, no operand consumed.
- `ib_valid` dropped for 3 cycles mid-operands, and `stall` held for 2 cycles in ITER → counter, `uc_adr` and `ib_rd` frozen; final result identical to the unstalled run.
- Reset asserted during ITER on chain 0x60→0x200→0x201→0 → all outputs return to reset values; after release the next byte is treated as an opcode.
